// File: rtl/banner_scroll_if.sv
// Banner ROM and pixel-row bus between banner_scroll_ctrl and its neighbours.
// master: the controller (drives ROM address and pixel rows).
// slave : the ROM / display-writer side.
interface banner_scroll_if #(
  parameter int ROM_W = 70,
  parameter int WIN_W = 32
);
  logic [4:0]       rom_addr;
  logic [ROM_W-1:0] rom_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [WIN_W-1:0] pix_data;
  logic [4:0]       pix_row;
  logic             pix_last;

  modport master (
    output rom_addr,
    input  rom_data,
    output pix_valid,
    input  pix_ready,
    output pix_data,
    output pix_row,
    output pix_last
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  pix_valid,
    output pix_ready,
    input  pix_data,
    input  pix_row,
    input  pix_last
  );
endinterface

// File: rtl/banner_scroll_ctrl.sv
// Banner scroll controller: walks a 1-cycle-latency row ROM once per frame and
// hands a horizontally scrolled WIN_W-column window of each row downstream.
// The scroll offset advances one column every SCROLL_DIV completed frames.
// Optional build macro BANNER_BLINK_EN: blanks pix_data on alternate groups
// of BLINK_FRAMES frames (timing and handshakes unchanged).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// ADDR   | rom_addr = current row, ROM samples it on the next edge
// WAIT   | ROM data becomes valid; window loaded at the next edge
// DATA   | pix_valid high, holding the row until pix_ready
// DONE   | one-cycle frame_done; frame / scroll counters advance
module banner_scroll_ctrl #(
  parameter int ROWS         = 15,
  parameter int ROM_W        = 70,
  parameter int WIN_W        = 32,
  parameter int SCROLL_DIV   = 4
`ifdef BANNER_BLINK_EN
  , parameter int BLINK_FRAMES = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  banner_scroll_if.master        bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic [6:0]             offset
);

  localparam int FCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [4:0]       row;
  logic [FCW-1:0]   frame_cnt;
  logic             last_row;
  logic [WIN_W-1:0] window;
  logic [WIN_W-1:0] pix_load;

  assign last_row = (row == 5'(ROWS - 1));

`ifdef BANNER_BLINK_EN
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BCW-1:0] blink_cnt;
  logic           blink_on;
  assign pix_load = blink_on ? '0 : window;
`else
  assign pix_load = window;
`endif

  // Extract the visible window from the ROM row, wrapping past the last column.
  always_comb begin
    int idx;
    window = '0;
    idx    = 0;
    for (int c = 0; c < WIN_W; c++) begin
      idx = int'(offset) + c;
      if (idx >= ROM_W) idx = idx - ROM_W;
      window[WIN_W-1-c] = bus.rom_data[ROM_W-1-idx];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_DATA;
      S_DATA: if (bus.pix_ready) state_nxt = last_row ? S_DONE : S_ADDR;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy          = (state != S_IDLE);
    frame_done    = (state == S_DONE);
    bus.pix_valid = (state == S_DATA);
    bus.pix_last  = (state == S_DATA) && (bus.pix_row == 5'(ROWS - 1));
  end

  // Row sequencing, ROM address, output row register and frame/scroll counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      bus.rom_addr <= '0;
      bus.pix_data <= '0;
      bus.pix_row  <= '0;
      frame_cnt    <= '0;
      offset       <= '0;
`ifdef BANNER_BLINK_EN
      blink_cnt    <= '0;
      blink_on     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row          <= '0;
            bus.rom_addr <= '0;
          end
        end
        S_WAIT: begin
          bus.pix_data <= pix_load;
          bus.pix_row  <= row;
        end
        S_DATA: begin
          if (bus.pix_ready && !last_row) begin
            row          <= row + 5'd1;
            bus.rom_addr <= row + 5'd1;
          end
        end
        S_DONE: begin
          if (frame_cnt == FCW'(SCROLL_DIV - 1)) begin
            frame_cnt <= '0;
            offset    <= (offset == 7'(ROM_W - 1)) ? 7'd0 : offset + 7'd1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
`ifdef BANNER_BLINK_EN
          if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl with a registered-address ROM model.
module tb_banner_scroll_ctrl;
  localparam int ROWS  = 15;
  localparam int ROM_W = 70;
  localparam int WIN_W = 32;
  localparam int SDIV  = 4;
`ifdef BANNER_BLINK_EN
  localparam int BF = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic [6:0] offset;

  int n_tests = 0;
  int n_fail  = 0;
  int eoff    = 0;
  int fc      = 0;
  int nframes = 0;
  int total   = 0;

  logic [ROM_W-1:0] rom [ROWS];

  banner_scroll_if #(.ROM_W(ROM_W), .WIN_W(WIN_W)) bus ();

  banner_scroll_ctrl #(
    .ROWS(ROWS), .ROM_W(ROM_W), .WIN_W(WIN_W), .SCROLL_DIV(SDIV)
`ifdef BANNER_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus.master),
    .busy(busy),
    .frame_done(frame_done),
    .offset(offset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] model_win(input int r, input int off);
    logic [WIN_W-1:0] w;
    logic [ROM_W-1:0] d;
    d = rom[r];
    for (int c = 0; c < WIN_W; c++) w[WIN_W-1-c] = d[ROM_W-1-((off + c) % ROM_W)];
    return w;
  endfunction

  function automatic bit is_blank();
`ifdef BANNER_BLINK_EN
    return ((nframes / BF) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_frame(input int stall_row, input int stall_len, input int pulse_row, input bit hold);
    int cyc = 0;
    int nxt = 0;
    int exp_valid_at = 3;
    int stall = 0;
    bit prev_valid = 1'b0;
    bit done_seen = 1'b0;
    bit pulsed = 1'b0;
    bit blank;
    logic [WIN_W-1:0] ew;
    blank = is_blank();
    start = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    chk("busy_after_start", 64'(busy), 64'd1);
    while (!done_seen && cyc < 300) begin
      if (!hold) start = 1'b0;
      if (bus.pix_valid && !prev_valid) chk("valid_latency", 64'(cyc), 64'(exp_valid_at));
      if (bus.pix_valid) begin
        ew = blank ? '0 : model_win(nxt, eoff);
        chk("pix_row", 64'(bus.pix_row), 64'(nxt));
        chk("pix_data", 64'(bus.pix_data), 64'(ew));
        chk("pix_last", 64'(bus.pix_last), 64'(nxt == ROWS - 1));
        if (!blank && eoff == 0 && nxt == 0) chk("row0_off0", 64'(bus.pix_data), 64'h FC7FC7E0);
        if (!blank && eoff == 0 && nxt >= 3 && nxt <= 11) chk("rowmid_off0", 64'(bus.pix_data), 64'h E00E01C7);
        if (!blank && eoff == 60 && nxt == 0) chk("row0_off60", 64'(bus.pix_data), 64'h 007F1FF1);
        if (nxt == pulse_row && !pulsed) begin
          start = 1'b1;
          pulsed = 1'b1;
        end
        if (nxt == stall_row && stall < stall_len) begin
          bus.pix_ready = 1'b0;
          stall++;
        end else begin
          bus.pix_ready = 1'b1;
          nxt++;
          exp_valid_at = cyc + 3;
        end
      end else begin
        bus.pix_ready = 1'b1;
      end
      if (frame_done) done_seen = 1'b1;
      prev_valid = bus.pix_valid;
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_seen", 64'(done_seen), 64'd1);
    chk("transfers", 64'(nxt), 64'(ROWS));
    chk("frame_done_pulse", 64'(frame_done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    nframes++;
    total++;
    fc++;
    if (fc == SDIV) begin
      fc = 0;
      eoff = (eoff == ROM_W - 1) ? 0 : eoff + 1;
    end
    chk("offset", 64'(offset), 64'(eoff));
  endtask

  initial begin
    bit found;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0)                rom[r] = {32'hFC7FC7E0, 38'h1};
      else if (r >= 3 && r <= 11) rom[r] = {32'hE00E01C7, 38'h2A_AAAA_AAAA};
      else                       rom[r] = {24'h5A3C96, 8'(r), 38'h15_5555_5555 ^ 38'(r)};
    end
    rst = 1'b1;
    start = 1'b0;
    bus.pix_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("rst_pix_last", 64'(bus.pix_last), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
    chk("rst_pix_data", 64'(bus.pix_data), 64'd0);
    chk("rst_pix_row", 64'(bus.pix_row), 64'd0);
    chk("rst_offset", 64'(offset), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(-1, 0, -1, 1'b0);
    run_frame(7, 5, -1, 1'b0);
    run_frame(-1, 0, 4, 1'b0);
    run_frame(-1, 0, -1, 1'b0);
    chk("offset_after_4", 64'(offset), 64'd1);

    while (total < 284) run_frame(-1, 0, -1, 1'b1);
    start = 1'b0;
    chk("offset_after_284", 64'(offset), 64'd1);
    @(negedge clk);
    chk("no_retrigger", 64'(busy), 64'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.rom_addr == 5'd9) found = 1'b1;
    end
    chk("reach_row9", 64'(found), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("abort_pix_last", 64'(bus.pix_last), 64'd0);
    chk("abort_frame_done", 64'(frame_done), 64'd0);
    chk("abort_rom_addr", 64'(bus.rom_addr), 64'd0);
    chk("abort_pix_data", 64'(bus.pix_data), 64'd0);
    chk("abort_pix_row", 64'(bus.pix_row), 64'd0);
    chk("abort_offset", 64'(offset), 64'd0);
    eoff = 0;
    fc = 0;
    nframes = 0;
    @(negedge clk);
    chk("abort_stays_idle", 64'(busy), 64'd0);

    for (int f = 0; f < 5; f++) run_frame(-1, 0, -1, 1'b0);
    chk("offset_after_5", 64'(offset), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
